jtag_master: RTL

- Host-side JTAG initiator. Generates TCK/TMS/TDI and samples TDO to drive an external or on-chip TAP from fabric logic, for example for board bring-up or loopback testing of the chain-1 user DR.
- Accepts one command at a time over a valid/ready handshake: TAP reset, IR shift, DR shift, or idle clocks.
- Returns captured TDO bits with a one-cycle response strobe.
- Leaves the TAP in Run-Test/Idle after every command.

---
 rtl/jtag_master.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/jtag_master.sv
// Host-side JTAG initiator: runs one TAP-reset, IR-shift, DR-shift or idle-clock command at a time,
// returns the captured TDO bits and always leaves the TAP in Run-Test/Idle.
module jtag_master #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned MAX_BITS = 32
) (
  input  logic                clk_sys_i,
  input  logic                rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [5:0]          cmd_len_i,
  input  logic [MAX_BITS-1:0] cmd_data_i,
  output logic                rsp_valid_o,
  output logic [MAX_BITS-1:0] rsp_data_o,
  output logic                busy_o,
  output logic                jtag_tck_o,
  output logic                jtag_tms_o,
  output logic                jtag_tdi_o,
  input  logic                jtag_tdo_i
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned CntW = 7;
  localparam logic [1:0] OpReset = 2'b00;
  localparam logic [1:0] OpIr    = 2'b01;
  localparam logic [1:0] OpDr    = 2'b10;
  localparam logic [1:0] OpIdle  = 2'b11;

  typedef enum logic [2:0] {StIdle, StPre, StShift, StPost, StDone} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [CntW-1:0]     n_q, n_d, step_q, step_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [MAX_BITS-1:0] shreg_q, shreg_d, cap_q, cap_d, rsp_q, rsp_d;

  logic            running, div_wrap, tck_rise, tck_fall, step_last, shift_op;
  logic [CntW-1:0] pre_len, eff_len;

  // TMS value for navigation step `step` of the lead-in sequence.
  function automatic logic pre_tms(logic [1:0] op, logic [CntW-1:0] step);
    case (op)
      OpReset: return step < CntW'(5);
      OpIr:    return step < CntW'(2);
      OpDr:    return step == '0;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    eff_len = CntW'(cmd_len_i);
    if (cmd_op_i != OpIdle) begin
      if (eff_len == '0) eff_len = CntW'(1);
      else if (eff_len > CntW'(MAX_BITS)) eff_len = CntW'(MAX_BITS);
    end
  end

  always_comb begin
    case (op_q)
      OpReset: pre_len = CntW'(6);
      OpIr:    pre_len = CntW'(4);
      OpDr:    pre_len = CntW'(3);
      default: pre_len = n_q;
    endcase
  end

  always_comb begin
    case (state_q)
      StPre:   step_last = (step_q == pre_len - 1'b1);
      StShift: step_last = (step_q == n_q - 1'b1);
      default: step_last = (step_q == CntW'(1));
    endcase
  end

  assign shift_op = (op_q == OpIr) || (op_q == OpDr);
  // An idle-clock command of length 0 sits in StPre for one cycle without toggling TCK.
  assign running  = ((state_q == StPre) && (pre_len != '0)) ||
                    (state_q == StShift) || (state_q == StPost);
  assign div_wrap = (div_q == DivW'(CLK_DIV - 1));
  assign tck_rise = running && div_wrap && !tck_q;
  assign tck_fall = running && div_wrap && tck_q;

  // State register
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cmd_valid_i) state_d = StPre;
      StPre: begin
        if (pre_len == '0) state_d = StDone;
        else if (tck_fall && step_last) state_d = shift_op ? StShift : StDone;
      end
      StShift: if (tck_fall && step_last) state_d = StPost;
      StPost:  if (tck_fall && step_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_ready_o = 1'b0;
    busy_o      = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      StIdle:                 cmd_ready_o = 1'b1;
      StPre, StShift, StPost: busy_o      = 1'b1;
      StDone:                 rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign jtag_tck_o = tck_q;
  assign jtag_tms_o = tms_q;
  assign jtag_tdi_o = tdi_q;
  assign rsp_data_o = rsp_q;

  // Datapath: TCK divider, TMS/TDI sequencing and TDO capture
  always_comb begin
    op_d    = op_q;
    n_d     = n_q;
    step_d  = step_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    shreg_d = shreg_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;

    if ((state_q == StIdle) && cmd_valid_i) begin
      op_d    = cmd_op_i;
      n_d     = eff_len;
      step_d  = '0;
      div_d   = '0;
      tck_d   = 1'b0;
      tms_d   = pre_tms(cmd_op_i, '0);
      shreg_d = cmd_data_i;
      cap_d   = '0;
    end

    if (running) begin
      div_d = div_wrap ? '0 : div_q + 1'b1;
      if (div_wrap) tck_d = ~tck_q;
    end

    // Captured bits enter at the top; the final right shift aligns bit 0 to the first one shifted.
    if (tck_rise && (state_q == StShift)) cap_d = {jtag_tdo_i, cap_q[MAX_BITS-1:1]};

    if (tck_fall) begin
      step_d = step_last ? '0 : step_q + 1'b1;
      case (state_q)
        StPre: begin
          if (!step_last) begin
            tms_d = pre_tms(op_q, step_q + 1'b1);
          end else if (shift_op) begin
            tms_d   = (n_q == CntW'(1));
            tdi_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
        StShift: begin
          if (step_last) begin
            tms_d = 1'b1;
          end else begin
            tms_d   = (step_q + CntW'(2) == n_q);
            tdi_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
        StPost:  tms_d = 1'b0;
        default: ;
      endcase
    end

    if ((state_d == StDone) && (state_q != StDone)) begin
      rsp_d = shift_op ? (cap_q >> (CntW'(MAX_BITS) - n_q)) : '0;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q    <= OpReset;
      n_q     <= '0;
      step_q  <= '0;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      shreg_q <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
    end else begin
      op_q    <= op_d;
      n_q     <= n_d;
      step_q  <= step_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      shreg_q <= shreg_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
    end
  end

endmodule
